rvfi_retire_monitor: RTL and testbench

//   Synthesizable retire monitor for the mp4 RV32I core. Generalises the single-issue commit/halt hookup
//   to NUM_RET in-order retire lanes. Per cycle it produces registered RVFI commit strobes and per-lane

---
 rtl/rvfi_mon_pkg.sv | 15 +
 rtl/ret_prefix_count.sv | 27 ++
 rtl/rvfi_retire_monitor.sv | 189 ++++++++++++++++++
 tb/tb_rvfi_retire_monitor.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rvfi_mon_pkg.sv
// Shared types for the RVFI retire monitor.
//   halt_cause_t : why the monitor stopped committing (2 bits)
//   RV_XLEN      : architectural register / PC width of the RV32I core
package rvfi_mon_pkg;

  localparam int unsigned RV_XLEN = 32;

  typedef enum logic [1:0] {
    HC_NONE    = 2'd0,
    HC_LOOP    = 2'd1,
    HC_TRAP    = 2'd2,
    HC_TIMEOUT = 2'd3
  } halt_cause_t;

endpackage

// File: rtl/ret_prefix_count.sv
// Per-lane exclusive prefix count and total popcount of a lane mask.
//   mask_i   : N-bit lane mask, bit 0 is the oldest lane
//   prefix_o : prefix_o[k] = number of set bits in mask_i[k-1:0]
//   total_o  : number of set bits in mask_i
module ret_prefix_count #(
  parameter int unsigned N  = 2,
  parameter int unsigned CW = $clog2(N + 1)
) (
  input  logic [N-1:0]         mask_i,
  output logic [N-1:0][CW-1:0] prefix_o,
  output logic [CW-1:0]        total_o
);

  logic [CW-1:0] run;

  // NOTE: blocking assignments are correct here: 'run' is a combinational
  // running sum, each lane must see the value left by the lane before it.
  always_comb begin
    run = '0;
    for (int k = 0; k < N; k++) begin
      prefix_o[k] = run;
      run         = run + CW'(mask_i[k]);
    end
    total_o = run;
  end

endmodule

// File: rtl/rvfi_retire_monitor.sv
// Retire monitor for an in-order, NUM_RET-wide retire stage.
// Converts retire lanes into registered RVFI commit strobes and order numbers
// and raises sticky end-of-simulation status (halt, cause, timeout, lane_err).
//   clk, reset    : rising-edge clock, asynchronous active-low reset
//   ret_valid     : per-lane retire valid (lane 0 oldest)
//   ret_pc_rdata  : per-lane PC of the retiring instruction
//   ret_pc_wdata  : per-lane next PC of the retiring instruction
//   ret_trap      : per-lane trap flag
//   commit, order : registered commit strobe and order number per lane
//   halt          : sticky stop (self-loop, trap or watchdog)
//   halt_cause    : first cause that stopped the monitor
//   timeout       : sticky watchdog expiry
//   lane_err      : sticky non-contiguous ret_valid
//   retired_cnt   : total committed instructions (modulo 2^ORDER_W)
module rvfi_retire_monitor
  import rvfi_mon_pkg::*;
#(
  parameter int unsigned NUM_RET     = 2,
  parameter int unsigned ORDER_W     = 64,
  parameter int unsigned HALT_REPEAT = 2,
  parameter int unsigned WDOG_CYCLES = 100000
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_RET-1:0]               ret_valid,
  input  logic [NUM_RET-1:0][RV_XLEN-1:0]  ret_pc_rdata,
  input  logic [NUM_RET-1:0][RV_XLEN-1:0]  ret_pc_wdata,
  input  logic [NUM_RET-1:0]               ret_trap,
  output logic [NUM_RET-1:0]               commit,
  output logic [NUM_RET-1:0][ORDER_W-1:0]  order,
  output logic                             halt,
  output halt_cause_t                      halt_cause,
  output logic                             timeout,
  output logic                             lane_err,
  output logic [ORDER_W-1:0]               retired_cnt
);

  localparam int unsigned CNT_W  = $clog2(NUM_RET + 1);
  localparam int unsigned LOOP_W = $clog2(HALT_REPEAT + 1);
  localparam int unsigned IDLE_W = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES + 1) : 1;

  localparam logic [LOOP_W-1:0] LOOP_MAX  = LOOP_W'(HALT_REPEAT);
  localparam logic [LOOP_W-1:0] LOOP_ONE  = LOOP_W'(1);
  localparam logic [IDLE_W-1:0] IDLE_ONE  = IDLE_W'(1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'((WDOG_CYCLES > 0) ? WDOG_CYCLES - 1 : 0);

  // State
  logic [NUM_RET-1:0]              commit_q;
  logic [NUM_RET-1:0][ORDER_W-1:0] order_q,   order_d;
  logic [ORDER_W-1:0]              base_q,    base_d;
  logic [LOOP_W-1:0]               loop_q,    loop_d;
  logic [IDLE_W-1:0]               idle_q,    idle_d;
  logic                            halt_q,    halt_d;
  halt_cause_t                     cause_q,   cause_d;
  logic                            timeout_q, timeout_d;
  logic                            err_q,     err_d;

  // Combinational helpers
  logic                        stop;
  logic [NUM_RET-1:0]          accept;
  logic [NUM_RET-1:0][CNT_W-1:0] prefix;
  logic [CNT_W-1:0]            total;
  logic                        loop_hit;
  logic                        trap_hit;
  logic                        gap;
  logic                        seen_idle;
  logic                        wdog_fire;

  assign stop     = halt_q | timeout_q;
  assign accept   = ret_valid & {NUM_RET{~stop}};
  assign trap_hit = |(accept & ret_trap);

  ret_prefix_count #(
    .N  (NUM_RET),
    .CW (CNT_W)
  ) u_prefix (
    .mask_i   (accept),
    .prefix_o (prefix),
    .total_o  (total)
  );

  // Order numbers: committing lanes get base + offset among committers,
  // idle lanes just show the current base.
  always_comb begin
    for (int k = 0; k < NUM_RET; k++) begin
      order_d[k] = accept[k] ? base_q + ORDER_W'(prefix[k]) : base_q;
    end
    base_d = base_q + ORDER_W'(total);
  end

  // A valid lane above an invalid one means the retire stage skipped a slot.
  always_comb begin
    seen_idle = 1'b0;
    gap       = 1'b0;
    for (int k = 0; k < NUM_RET; k++) begin
      if (!ret_valid[k])  seen_idle = 1'b1;
      else if (seen_idle) gap       = 1'b1;
    end
  end

  // Self-loop detection walks lanes oldest-first so the count behaves as if
  // the lanes had retired in consecutive cycles. Reaching the limit at any
  // lane halts, even if a younger lane in the same cycle clears the count.
  always_comb begin
    loop_d   = loop_q;
    loop_hit = 1'b0;
    for (int k = 0; k < NUM_RET; k++) begin
      if (accept[k]) begin
        if (ret_pc_wdata[k] == ret_pc_rdata[k]) begin
          if (loop_d != LOOP_MAX) loop_d = loop_d + LOOP_ONE;
        end else begin
          loop_d = '0;
        end
        if (loop_d == LOOP_MAX) loop_hit = 1'b1;
      end
    end
  end

  // Watchdog: counts commit-free cycles, saturating; frozen once stopped.
  assign wdog_fire = (WDOG_CYCLES != 0) && !stop && (total == '0) && (idle_q == IDLE_LAST);

  always_comb begin
    idle_d = idle_q;
    if (!stop) begin
      if (total != '0)       idle_d = '0;
      else if (idle_q != '1) idle_d = idle_q + IDLE_ONE;
    end
  end

  // Sticky status. Cause is written only on the first stop; trap outranks
  // loop, and a watchdog firing implies no commit so it cannot collide.
  // NOTE: every output of this block gets a default first so no path leaves
  // a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    halt_d    = halt_q;
    cause_d   = cause_q;
    timeout_d = timeout_q;
    err_d     = err_q | gap;
    if (!halt_q) begin
      if (trap_hit) begin
        halt_d  = 1'b1;
        cause_d = HC_TRAP;
      end else if (loop_hit) begin
        halt_d  = 1'b1;
        cause_d = HC_LOOP;
      end else if (wdog_fire) begin
        halt_d    = 1'b1;
        timeout_d = 1'b1;
        cause_d   = HC_TIMEOUT;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      commit_q  <= '0;
      order_q   <= '0;
      base_q    <= '0;
      loop_q    <= '0;
      idle_q    <= '0;
      halt_q    <= 1'b0;
      cause_q   <= HC_NONE;
      timeout_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      commit_q <= accept;
      // Order is held once stopped so the last committed numbers stay visible.
      if (!stop) order_q <= order_d;
      base_q    <= base_d;
      loop_q    <= loop_d;
      idle_q    <= idle_d;
      halt_q    <= halt_d;
      cause_q   <= cause_d;
      timeout_q <= timeout_d;
      err_q     <= err_d;
    end
  end

  assign commit      = commit_q;
  assign order       = order_q;
  assign halt        = halt_q;
  assign halt_cause  = cause_q;
  assign timeout     = timeout_q;
  assign lane_err    = err_q;
  assign retired_cnt = base_q;

endmodule

// File: tb/tb_rvfi_retire_monitor.sv
// Self-checking bench for rvfi_retire_monitor (2 lanes, 5-bit order,
// HALT_REPEAT=2, WDOG_CYCLES=8): directed table, hand-written watchdog /
// async-reset / wrap sequences, then random traffic against a reference model.
module tb_rvfi_retire_monitor;
  import rvfi_mon_pkg::*;

  localparam int NR  = 2;
  localparam int OW  = 5;
  localparam int HR  = 2;
  localparam int WD  = 8;
  localparam int MOD = 1 << OW;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NR-1:0]         ret_valid;
  logic [NR-1:0][31:0]   ret_pc_rdata;
  logic [NR-1:0][31:0]   ret_pc_wdata;
  logic [NR-1:0]         ret_trap;
  logic [NR-1:0]         commit;
  logic [NR-1:0][OW-1:0] order;
  logic                  halt;
  halt_cause_t           halt_cause;
  logic                  timeout;
  logic                  lane_err;
  logic [OW-1:0]         retired_cnt;

  always #5 clk = ~clk;

  rvfi_retire_monitor #(
    .NUM_RET     (NR),
    .ORDER_W     (OW),
    .HALT_REPEAT (HR),
    .WDOG_CYCLES (WD)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .ret_valid    (ret_valid),
    .ret_pc_rdata (ret_pc_rdata),
    .ret_pc_wdata (ret_pc_wdata),
    .ret_trap     (ret_trap),
    .commit       (commit),
    .order        (order),
    .halt         (halt),
    .halt_cause   (halt_cause),
    .timeout      (timeout),
    .lane_err     (lane_err),
    .retired_cnt  (retired_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model (whole-cycle, integer arithmetic) ----
  int          m_base, m_loop, m_idle;
  bit          m_halt, m_tout, m_err;
  halt_cause_t m_cause;
  logic [NR-1:0] e_commit;
  int          e_order [NR];

  task automatic model_reset();
    m_base = 0; m_loop = 0; m_idle = 0;
    m_halt = 0; m_tout = 0; m_err = 0;
    m_cause = HC_NONE;
  endtask

  task automatic model_step(input logic [NR-1:0] v, input logic [NR-1:0][31:0] pr,
                            input logic [NR-1:0][31:0] pw, input logic [NR-1:0] tr);
    int  vi, n;
    bit  stopped, loop_hit, trap_hit;
    vi = int'(v);
    stopped = m_halt || m_tout;
    // A contiguous mask is of the form 0..01..1, i.e. v & (v+1) == 0.
    if ((vi & (vi + 1)) != 0) m_err = 1;
    n = 0; loop_hit = 0; trap_hit = 0;
    e_commit = '0;
    for (int k = 0; k < NR; k++) begin
      e_order[k] = 0;
      if (v[k] && !stopped) begin
        e_commit[k] = 1'b1;
        e_order[k]  = (m_base + n) % MOD;
        n++;
        if (pw[k] == pr[k]) m_loop++; else m_loop = 0;
        if (m_loop >= HR) loop_hit = 1;
        if (tr[k]) trap_hit = 1;
      end
    end
    m_base = (m_base + n) % MOD;
    if (!stopped) begin
      if (trap_hit) begin
        m_halt = 1; m_cause = HC_TRAP;
      end else if (loop_hit) begin
        m_halt = 1; m_cause = HC_LOOP;
      end else if (n == 0) begin
        if (m_idle == WD - 1) begin
          m_halt = 1; m_tout = 1; m_cause = HC_TIMEOUT;
        end
        m_idle++;
      end
    end
    if (n > 0) m_idle = 0;
  endtask

  // ---------------- stimulus helpers ------------------------------------
  task automatic apply(input logic [NR-1:0] v, input logic [NR-1:0][31:0] pr,
                       input logic [NR-1:0][31:0] pw, input logic [NR-1:0] tr);
    ret_valid    = v;
    ret_pc_rdata = pr;
    ret_pc_wdata = pw;
    ret_trap     = tr;
  endtask

  // Leaves the bench at a negedge with reset released.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    apply('0, '0, '0, '0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  // ---------------- directed table --------------------------------------
  typedef struct {
    bit              rst;
    logic [1:0]      v;
    logic [1:0][31:0] pr;
    logic [1:0][31:0] pw;
    logic [1:0]      tr;
    logic [1:0]      e_commit;
    logic [1:0]      om;       // lanes whose order is checked
    logic [4:0]      o0, o1;
    logic            e_halt;
    halt_cause_t     e_cause;
    logic            e_err;
    logic [4:0]      e_ret;
  } vec_t;

  function automatic vec_t row(bit rst, logic [1:0] v, logic [31:0] pr0, logic [31:0] pw0,
                               logic [31:0] pr1, logic [31:0] pw1, logic [1:0] tr,
                               logic [1:0] ec, logic [1:0] om, logic [4:0] o0, logic [4:0] o1,
                               logic h, halt_cause_t c, logic e, logic [4:0] rc);
    vec_t r;
    r.rst = rst; r.v = v; r.tr = tr;
    r.pr[0] = pr0; r.pw[0] = pw0; r.pr[1] = pr1; r.pw[1] = pw1;
    r.e_commit = ec; r.om = om; r.o0 = o0; r.o1 = o1;
    r.e_halt = h; r.e_cause = c; r.e_err = e; r.e_ret = rc;
    return r;
  endfunction

  localparam int NV = 18;
  vec_t tbl [NV];

  initial begin
    logic [1:0][31:0] pr, pw;
    logic [1:0]       v, tr;
    int               p_idle;

    reset = 1'b0;
    apply('0, '0, '0, '0);
    model_reset();
    #2;
    check("reset commit",  commit, 0);
    check("reset order",   order, 0);
    check("reset halt",    halt, 0);
    check("reset cause",   halt_cause, HC_NONE);
    check("reset timeout", timeout, 0);
    check("reset lane_err", lane_err, 0);
    check("reset retired", retired_cnt, 0);

    //                  rst v      pr0    pw0    pr1    pw1    tr     ec     om     o0 o1 h  cause       e  rc
    tbl[0]  = row(1, 2'b11, 'h100, 'h104, 'h104, 'h108, 2'b00, 2'b11, 2'b11, 0, 1, 0, HC_NONE, 0, 2);
    tbl[1]  = row(0, 2'b11, 'h108, 'h10c, 'h10c, 'h110, 2'b00, 2'b11, 2'b11, 2, 3, 0, HC_NONE, 0, 4);
    tbl[2]  = row(0, 2'b11, 'h110, 'h114, 'h114, 'h118, 2'b00, 2'b11, 2'b11, 4, 5, 0, HC_NONE, 0, 6);
    tbl[3]  = row(0, 2'b01, 'h118, 'h11c, 'h0,   'h0,   2'b00, 2'b01, 2'b01, 6, 0, 0, HC_NONE, 0, 7);
    tbl[4]  = row(0, 2'b11, 'h11c, 'h120, 'h120, 'h124, 2'b00, 2'b11, 2'b11, 7, 8, 0, HC_NONE, 0, 9);
    tbl[5]  = row(0, 2'b10, 'h0,   'h0,   'h124, 'h128, 2'b00, 2'b10, 2'b10, 0, 9, 0, HC_NONE, 1, 10);
    tbl[6]  = row(0, 2'b00, 'h0,   'h0,   'h0,   'h0,   2'b00, 2'b00, 2'b00, 0, 0, 0, HC_NONE, 1, 10);
    tbl[7]  = row(0, 2'b01, 'h60,  'h60,  'h0,   'h0,   2'b00, 2'b01, 2'b01, 10, 0, 0, HC_NONE, 1, 11);
    tbl[8]  = row(0, 2'b01, 'h60,  'h60,  'h0,   'h0,   2'b00, 2'b01, 2'b01, 11, 0, 1, HC_LOOP, 1, 12);
    tbl[9]  = row(0, 2'b11, 'h200, 'h204, 'h204, 'h208, 2'b00, 2'b00, 2'b01, 11, 0, 1, HC_LOOP, 1, 12);
    tbl[10] = row(1, 2'b11, 'h80,  'h80,  'h84,  'h88,  2'b10, 2'b11, 2'b11, 0, 1, 1, HC_TRAP, 0, 2);
    tbl[11] = row(1, 2'b01, 'h100, 'h104, 'h0,   'h0,   2'b10, 2'b01, 2'b01, 0, 0, 0, HC_NONE, 0, 1);
    tbl[12] = row(0, 2'b11, 'h40,  'h40,  'h44,  'h44,  2'b00, 2'b11, 2'b11, 1, 2, 1, HC_LOOP, 0, 3);
    tbl[13] = row(1, 2'b11, 'h40,  'h40,  'h44,  'h48,  2'b00, 2'b11, 2'b11, 0, 1, 0, HC_NONE, 0, 2);
    tbl[14] = row(0, 2'b01, 'h50,  'h50,  'h0,   'h0,   2'b00, 2'b01, 2'b01, 2, 0, 0, HC_NONE, 0, 3);
    tbl[15] = row(0, 2'b01, 'h50,  'h50,  'h0,   'h0,   2'b00, 2'b01, 2'b01, 3, 0, 1, HC_LOOP, 0, 4);
    tbl[16] = row(1, 2'b11, 'h40,  'h44,  'h44,  'h44,  2'b00, 2'b11, 2'b11, 0, 1, 0, HC_NONE, 0, 2);
    tbl[17] = row(0, 2'b01, 'h44,  'h44,  'h0,   'h0,   2'b00, 2'b01, 2'b01, 2, 0, 1, HC_LOOP, 0, 3);

    for (int i = 0; i < NV; i++) begin
      if (tbl[i].rst) do_reset(); else @(negedge clk);
      apply(tbl[i].v, tbl[i].pr, tbl[i].pw, tbl[i].tr);
      @(posedge clk); #1;
      check($sformatf("row%0d commit", i), commit, tbl[i].e_commit);
      if (tbl[i].om[0]) check($sformatf("row%0d order0", i), order[0], tbl[i].o0);
      if (tbl[i].om[1]) check($sformatf("row%0d order1", i), order[1], tbl[i].o1);
      check($sformatf("row%0d halt", i),     halt, tbl[i].e_halt);
      check($sformatf("row%0d cause", i),    halt_cause, tbl[i].e_cause);
      check($sformatf("row%0d lane_err", i), lane_err, tbl[i].e_err);
      check($sformatf("row%0d timeout", i),  timeout, 0);
      check($sformatf("row%0d retired", i),  retired_cnt, tbl[i].e_ret);
    end

    // ---- order wrap-around: 17 full cycles cross 2^5 ----
    do_reset();
    for (int i = 0; i < 17; i++) begin
      if (i > 0) @(negedge clk);
      pr[0] = 32'h1000 + 32'(8 * i); pw[0] = pr[0] + 4;
      pr[1] = pw[0];                  pw[1] = pr[1] + 4;
      apply(2'b11, pr, pw, 2'b00);
      @(posedge clk); #1;
      check($sformatf("wrap%0d order0", i), order[0], (2 * i) % MOD);
      check($sformatf("wrap%0d order1", i), order[1], (2 * i + 1) % MOD);
      check($sformatf("wrap%0d retired", i), retired_cnt, (2 * i + 2) % MOD);
    end

    // ---- async reset mid watchdog count, then full timeout ----
    do_reset();
    apply(2'b10, '0, '0, '0);
    @(posedge clk); #1;
    check("async pre lane_err", lane_err, 1);
    @(negedge clk);
    apply('0, '0, '0, '0);
    repeat (4) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("async commit",   commit, 0);
    check("async order",    order, 0);
    check("async retired",  retired_cnt, 0);
    check("async lane_err", lane_err, 0);
    check("async halt",     halt, 0);
    check("async timeout",  timeout, 0);
    check("async cause",    halt_cause, HC_NONE);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 1; i <= WD; i++) begin
      @(posedge clk); #1;
      check($sformatf("wdog edge%0d timeout", i), timeout, (i == WD));
      check($sformatf("wdog edge%0d halt", i),    halt, (i == WD));
    end
    check("wdog cause", halt_cause, HC_TIMEOUT);
    @(negedge clk);
    apply(2'b11, '0, 64'h4, '0);
    @(posedge clk); #1;
    check("wdog post commit",  commit, 0);
    check("wdog post retired", retired_cnt, 0);

    // ---- random traffic against the reference model ----
    for (int ep = 0; ep < 25; ep++) begin
      do_reset();
      p_idle = ($urandom_range(0, 3) == 0) ? 95 : $urandom_range(0, 40);
      for (int c = 0; c < 40; c++) begin
        if (c > 0) @(negedge clk);
        v = ($urandom_range(0, 99) < p_idle) ? 2'b00 : 2'($urandom_range(1, 3));
        for (int k = 0; k < NR; k++) begin
          pr[k] = {$urandom_range(0, 'hffff), 2'b00} ;
          pw[k] = ($urandom_range(0, 7) == 0) ? pr[k] : pr[k] + 4;
          tr[k] = ($urandom_range(0, 39) == 0);
        end
        apply(v, pr, pw, tr);
        model_step(v, pr, pw, tr);
        @(posedge clk); #1;
        check($sformatf("rnd%0d.%0d commit", ep, c), commit, e_commit);
        for (int k = 0; k < NR; k++)
          if (e_commit[k]) check($sformatf("rnd%0d.%0d order%0d", ep, c, k), order[k], e_order[k]);
        check($sformatf("rnd%0d.%0d retired", ep, c),  retired_cnt, m_base);
        check($sformatf("rnd%0d.%0d halt", ep, c),     halt, m_halt);
        check($sformatf("rnd%0d.%0d cause", ep, c),    halt_cause, m_cause);
        check($sformatf("rnd%0d.%0d timeout", ep, c),  timeout, m_tout);
        check($sformatf("rnd%0d.%0d lane_err", ep, c), lane_err, m_err);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
